// File: rtl/spi_sram_master.sv
// rtl/spi_sram_master.sv - SPI SRAM master: 41-bit read/write frames with a 3-clock cs_n gap.
// Optional SPI_SRAM_MASTER_RDATA0_EN exposes the early read byte and its load strobe.
module spi_sram_master (
    input  logic        clk,
    input  logic        rst,
    input  logic        clkb,
    input  logic        en,
    input  logic        enb,
    output logic        cs_n,
    output logic        mosi,
    input  logic        miso,
    input  logic [23:0] mem_addr,
    input  logic        mem_en,
    input  logic        mem_wr,
    input  logic [7:0]  mem_wdata,
    output logic        mem_rdy,
    output logic [7:0]  mem_rdata,
    output logic [7:0]  mem_rdata0,
    output logic        mem_rdata_load
);

    typedef enum logic [2:0] {GAP, CMD, ADDR, DUMMY, DATA, DONE} state_t;

    state_t      state_q;
    logic [5:0]  cnt_q;
    logic [1:0]  gap_q;
    logic [23:0] addr_q;
    logic        wr_q;
    logic [7:0]  wdata_q;
    logic [6:0]  shift_q;
    logic        rdy_q;
    logic [7:0]  rdata_q;
    logic        cs_n_q;
    logic        mosi_q;
    logic        cs_n_d;
    logic        mosi_d;

    logic        in_frame;
    logic        launch;
    logic        last_bit;
    logic [7:0]  cmd_byte;
    logic [7:0]  rd_byte;

    assign in_frame = (state_q == CMD) || (state_q == ADDR) ||
                      (state_q == DUMMY) || (state_q == DATA);
    // Bit 0 (command MSB, always 0) goes out on the falling edge before the
    // start clock, so the start clock itself already samples the first bit.
    assign launch   = in_frame || ((state_q == GAP) && (gap_q == 2'd2) && mem_en);
    assign last_bit = (state_q == DATA) && (cnt_q == 6'd40);
    assign cmd_byte = {7'b0000001, ~wr_q};
    assign rd_byte  = {shift_q, miso};

    always_comb begin
        mosi_d = 1'b0;
        cs_n_d = ~launch;
        case (state_q)
            CMD:     mosi_d = cmd_byte[3'(6'd7 - cnt_q)];
            ADDR:    mosi_d = addr_q[5'(6'd31 - cnt_q)];
            DATA:    mosi_d = wr_q & wdata_q[3'(6'd40 - cnt_q)];
            default: mosi_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= GAP;
            cnt_q   <= 6'd0;
            gap_q   <= 2'd2;
            addr_q  <= 24'd0;
            wr_q    <= 1'b0;
            wdata_q <= 8'd0;
            shift_q <= 7'd0;
            rdy_q   <= 1'b0;
            rdata_q <= 8'd0;
        end else if (en) begin
            rdy_q <= 1'b0;
            case (state_q)
                GAP: begin
                    if (gap_q != 2'd2) begin
                        gap_q <= gap_q + 2'd1;
                    end else if (!cs_n_q) begin
                        state_q <= CMD;
                        cnt_q   <= 6'd1;
                        addr_q  <= mem_addr;
                        wr_q    <= mem_wr;
                        wdata_q <= mem_wdata;
                    end
                end
                CMD: begin
                    cnt_q <= cnt_q + 6'd1;
                    if (cnt_q == 6'd7) state_q <= ADDR;
                end
                ADDR: begin
                    cnt_q <= cnt_q + 6'd1;
                    if (cnt_q == 6'd31) state_q <= DUMMY;
                end
                DUMMY: begin
                    cnt_q   <= cnt_q + 6'd1;
                    state_q <= DATA;
                end
                DATA: begin
                    if (!wr_q) shift_q <= {shift_q[5:0], miso};
                    if (last_bit) begin
                        state_q <= DONE;
                        cnt_q   <= 6'd0;
                        rdy_q   <= 1'b1;
                        if (!wr_q) rdata_q <= rd_byte;
                    end else begin
                        cnt_q <= cnt_q + 6'd1;
                    end
                end
                DONE: begin
                    state_q <= GAP;
                    gap_q   <= 2'd0;
                end
                default: state_q <= GAP;
            endcase
        end
    end

    always_ff @(posedge clkb) begin
        if (rst) begin
            cs_n_q <= 1'b1;
            mosi_q <= 1'b0;
        end else if (enb) begin
            cs_n_q <= cs_n_d;
            mosi_q <= mosi_d & launch;
        end
    end

    assign cs_n      = cs_n_q;
    assign mosi      = mosi_q;
    assign mem_rdy   = rdy_q;
    assign mem_rdata = rdata_q;

`ifdef SPI_SRAM_MASTER_RDATA0_EN
    assign mem_rdata0     = rd_byte;
    assign mem_rdata_load = en & last_bit & ~wr_q;
`else
    assign mem_rdata0     = 8'd0;
    assign mem_rdata_load = 1'b0;
`endif

endmodule

// File: tb/tb_spi_sram_master.sv
// tb/tb_spi_sram_master.sv - directed bench for spi_sram_master with a behavioural SPI SRAM slave.
// Load-strobe expectations follow SPI_SRAM_MASTER_RDATA0_EN.
module tb_spi_sram_master;

    logic        clk = 1'b0;
    logic        clkb;
    logic        rst = 1'b1;
    logic        en = 1'b1;
    logic        enb = 1'b1;
    logic        miso = 1'b0;
    logic        mem_en = 1'b0;
    logic        mem_wr = 1'b0;
    logic [23:0] mem_addr = 24'd0;
    logic [7:0]  mem_wdata = 8'd0;
    logic        cs_n;
    logic        mosi;
    logic        mem_rdy;
    logic [7:0]  mem_rdata;
    logic [7:0]  mem_rdata0;
    logic        mem_rdata_load;

    spi_sram_master dut (
        .clk(clk), .rst(rst), .clkb(clkb), .en(en), .enb(enb),
        .cs_n(cs_n), .mosi(mosi), .miso(miso),
        .mem_addr(mem_addr), .mem_en(mem_en), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
        .mem_rdy(mem_rdy), .mem_rdata(mem_rdata), .mem_rdata0(mem_rdata0),
        .mem_rdata_load(mem_rdata_load)
    );

    always #5 clk = ~clk;
    assign clkb = ~clk;

`ifdef SPI_SRAM_MASTER_RDATA0_EN
    localparam int LOAD_PER_READ = 1;
`else
    localparam int LOAD_PER_READ = 0;
`endif

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    // slave model
    int          n = 0;
    logic [40:0] fr = '0;
    logic [40:0] last_frame = '0;
    logic [7:0]  rd_byte = 8'h00;
    logic [7:0]  mem [int];
    int          hi_run = 0;
    int          last_gap = 0;
    int          cs_low_cnt = 0;

    always @(posedge clk) begin
        cyc++;
        if (cs_n) begin
            hi_run++;
            n = 0;
        end else begin
            if (hi_run > 0) last_gap = hi_run;
            hi_run = 0;
            cs_low_cnt++;
            if (en) begin
                fr = {fr[39:0], mosi};
                n++;
                if (n == 32) rd_byte = mem.exists(int'(fr[23:0])) ? mem[int'(fr[23:0])] : 8'h00;
                if (n == 41) begin
                    last_frame = fr;
                    if (fr[40:33] == 8'h02) mem[int'(fr[32:9])] = fr[7:0];
                end
            end
        end
    end

    always @(negedge clk) begin
        miso = (n >= 33 && n <= 40) ? rd_byte[40 - n] : 1'b0;
    end

    int rdy_cnt = 0;
    int rdy_cyc = 0;
    int load_cnt = 0;

    always @(negedge clk) begin
        if (mem_rdy) begin
            rdy_cnt++;
            rdy_cyc = cyc;
        end
        if (mem_rdata_load) load_cnt++;
    end

    task automatic wait_rdy(input int start_cnt, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            #1;
            if (rdy_cnt > start_cnt) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        mem_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (cs_n !== 1'b1) begin errors++; $display("FAIL reset_cs_n: got %b expected 1", cs_n); end
        checks++; if (mosi !== 1'b0) begin errors++; $display("FAIL reset_mosi: got %b expected 0", mosi); end
        checks++; if (mem_rdy !== 1'b0) begin errors++; $display("FAIL reset_rdy: got %b expected 0", mem_rdy); end
        checks++; if (mem_rdata !== 8'h00) begin errors++; $display("FAIL reset_rdata: got %h expected 00", mem_rdata); end
        checks++; if (mem_rdata_load !== 1'b0) begin errors++; $display("FAIL reset_load: got %b expected 0", mem_rdata_load); end
        checks++; if (mem_rdata0 !== 8'h00) begin errors++; $display("FAIL reset_rdata0: got %h expected 00", mem_rdata0); end
    endtask

    task automatic test_first_read();
        int t0, base, base_load;
        bit ok;
        mem_addr = 24'h00FFFC;
        mem_wr = 1'b0;
        mem_en = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        t0 = cyc; base = rdy_cnt; base_load = load_cnt;
        wait_rdy(base, 100, ok);
        checks++; if (!ok) begin errors++; $display("FAIL first_rdy_seen: got none expected pulse"); end
        checks++; if (rdy_cyc - t0 != 41) begin errors++; $display("FAIL first_latency: got %0d expected 41", rdy_cyc - t0); end
        checks++; if (mem_rdata !== 8'h00) begin errors++; $display("FAIL first_rdata: got %h expected 00", mem_rdata); end
        checks++; if (last_frame !== {8'h03, 24'h00FFFC, 1'b0, 8'h00}) begin
            errors++; $display("FAIL first_mosi_frame: got %h expected %h", last_frame, {8'h03, 24'h00FFFC, 1'b0, 8'h00}); end
        checks++; if (load_cnt - base_load != LOAD_PER_READ) begin
            errors++; $display("FAIL first_load_count: got %0d expected %0d", load_cnt - base_load, LOAD_PER_READ); end
        @(posedge clk);
        #1;
        mem_en = 1'b0;
        checks++; if (mem_rdy !== 1'b0) begin errors++; $display("FAIL first_rdy_width: got %b expected 0", mem_rdy); end
    endtask

    task automatic test_back_to_back();
        int t0, base;
        bit ok;
        @(posedge clk);
        #1;
        rst = 1'b1;
        mem_addr = 24'h000400;
        mem_wr = 1'b0;
        mem_en = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        t0 = cyc; base = rdy_cnt;
        wait_rdy(base, 100, ok);
        checks++; if (rdy_cyc - t0 != 41 || !ok) begin errors++; $display("FAIL b2b_first_latency: got %0d expected 41", rdy_cyc - t0); end
        checks++; if (mem_rdata !== 8'hD8) begin errors++; $display("FAIL b2b_first_rdata: got %h expected d8", mem_rdata); end
        checks++; if (last_frame !== {8'h03, 24'h000400, 1'b0, 8'h00}) begin
            errors++; $display("FAIL b2b_first_frame: got %h expected %h", last_frame, {8'h03, 24'h000400, 1'b0, 8'h00}); end
        @(posedge clk);
        #1;
        mem_addr = 24'h000401;
        base = rdy_cnt;
        wait_rdy(base, 100, ok);
        checks++; if (rdy_cyc - t0 != 85 || !ok) begin errors++; $display("FAIL b2b_second_latency: got %0d expected 85", rdy_cyc - t0); end
        checks++; if (mem_rdata !== 8'hA9) begin errors++; $display("FAIL b2b_second_rdata: got %h expected a9", mem_rdata); end
        checks++; if (last_gap != 3) begin errors++; $display("FAIL b2b_cs_gap: got %0d expected 3", last_gap); end
        checks++; if (last_frame !== {8'h03, 24'h000401, 1'b0, 8'h00}) begin
            errors++; $display("FAIL b2b_second_frame: got %h expected %h", last_frame, {8'h03, 24'h000401, 1'b0, 8'h00}); end
        @(posedge clk);
        #1;
        mem_en = 1'b0;
    endtask

    task automatic test_idle_then_start();
        int t0, base, base_low;
        bit ok;
        repeat (4) @(posedge clk);
        #1;
        base = rdy_cnt; base_low = cs_low_cnt;
        repeat (100) @(posedge clk);
        #1;
        checks++; if (cs_low_cnt != base_low) begin errors++; $display("FAIL idle_cs_low: got %0d expected 0", cs_low_cnt - base_low); end
        checks++; if (rdy_cnt != base) begin errors++; $display("FAIL idle_rdy: got %0d expected 0", rdy_cnt - base); end
        mem_addr = 24'h000401;
        mem_wr = 1'b0;
        mem_en = 1'b1;
        t0 = cyc;
        @(posedge clk);
        #1;
        mem_en = 1'b0;
        checks++; if (cs_n !== 1'b0) begin errors++; $display("FAIL idle_start_cs: got %b expected 0", cs_n); end
        wait_rdy(base, 100, ok);
        checks++; if (rdy_cyc - t0 != 41 || !ok) begin errors++; $display("FAIL idle_latency: got %0d expected 41", rdy_cyc - t0); end
        checks++; if (mem_rdata !== 8'hA9) begin errors++; $display("FAIL idle_rdata: got %h expected a9", mem_rdata); end
    endtask

    task automatic test_write();
        int t0, base, base_load;
        bit ok;
        @(posedge clk);
        repeat (4) @(posedge clk);
        #1;
        mem_addr = 24'h000200;
        mem_wr = 1'b1;
        mem_wdata = 8'h55;
        mem_en = 1'b1;
        t0 = cyc; base = rdy_cnt; base_load = load_cnt;
        @(posedge clk);
        #1;
        mem_en = 1'b0;
        mem_addr = 24'h123456;
        mem_wdata = 8'hAA;
        mem_wr = 1'b0;
        wait_rdy(base, 100, ok);
        checks++; if (rdy_cyc - t0 != 41 || !ok) begin errors++; $display("FAIL write_latency: got %0d expected 41", rdy_cyc - t0); end
        checks++; if (mem_rdata !== 8'hA9) begin errors++; $display("FAIL write_rdata_held: got %h expected a9", mem_rdata); end
        checks++; if (last_frame !== {8'h02, 24'h000200, 1'b0, 8'h55}) begin
            errors++; $display("FAIL write_frame: got %h expected %h", last_frame, {8'h02, 24'h000200, 1'b0, 8'h55}); end
        checks++; if (load_cnt != base_load) begin errors++; $display("FAIL write_load: got %0d expected 0", load_cnt - base_load); end
        @(posedge clk);
        repeat (4) @(posedge clk);
        #1;
        mem_addr = 24'h000200;
        mem_en = 1'b1;
        base = rdy_cnt; base_load = load_cnt;
        @(posedge clk);
        #1;
        mem_en = 1'b0;
        wait_rdy(base, 100, ok);
        checks++; if (mem_rdata !== 8'h55 || !ok) begin errors++; $display("FAIL readback_rdata: got %h expected 55", mem_rdata); end
        checks++; if (load_cnt - base_load != LOAD_PER_READ) begin
            errors++; $display("FAIL readback_load: got %0d expected %0d", load_cnt - base_load, LOAD_PER_READ); end
    endtask

    task automatic test_abort();
        int t0, base;
        bit ok;
        @(posedge clk);
        repeat (4) @(posedge clk);
        #1;
        mem_addr = 24'h000400;
        mem_wr = 1'b0;
        mem_en = 1'b1;
        base = rdy_cnt;
        repeat (20) @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        #1;
        checks++; if (cs_n !== 1'b1) begin errors++; $display("FAIL abort_cs_n: got %b expected 1", cs_n); end
        @(posedge clk);
        @(posedge clk);
        #1;
        checks++; if (mem_rdata !== 8'h00) begin errors++; $display("FAIL abort_rdata_reset: got %h expected 00", mem_rdata); end
        mem_addr = 24'h000401;
        rst = 1'b0;
        t0 = cyc;
        wait_rdy(base, 100, ok);
        checks++; if (rdy_cyc - t0 != 41 || !ok) begin errors++; $display("FAIL abort_restart_latency: got %0d expected 41", rdy_cyc - t0); end
        checks++; if (rdy_cnt - base != 1) begin errors++; $display("FAIL abort_rdy_count: got %0d expected 1", rdy_cnt - base); end
        checks++; if (mem_rdata !== 8'hA9) begin errors++; $display("FAIL abort_rdata: got %h expected a9", mem_rdata); end
        @(posedge clk);
        #1;
        mem_en = 1'b0;
    endtask

    task automatic test_stretch();
        int t0, base;
        bit ok;
        repeat (4) @(posedge clk);
        #1;
        mem_addr = 24'h000400;
        mem_wr = 1'b0;
        mem_en = 1'b1;
        t0 = cyc; base = rdy_cnt;
        @(posedge clk);
        #1;
        mem_en = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        en = 1'b0;
        enb = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        en = 1'b1;
        enb = 1'b1;
        wait_rdy(base, 100, ok);
        checks++; if (rdy_cyc - t0 != 46 || !ok) begin errors++; $display("FAIL stretch_latency: got %0d expected 46", rdy_cyc - t0); end
        checks++; if (mem_rdata !== 8'hD8) begin errors++; $display("FAIL stretch_rdata: got %h expected d8", mem_rdata); end
        checks++; if (last_frame !== {8'h03, 24'h000400, 1'b0, 8'h00}) begin
            errors++; $display("FAIL stretch_frame: got %h expected %h", last_frame, {8'h03, 24'h000400, 1'b0, 8'h00}); end
    endtask

    initial begin
        mem[32'h400] = 8'hD8;
        mem[32'h401] = 8'hA9;
        test_reset();
        test_first_read();
        test_back_to_back();
        test_idle_then_start();
        test_write();
        test_abort();
        test_stretch();
        repeat (5) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
